// File: rtl/sfir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sfir_pkg
//  Description : Shared types and width helpers for the symmetric-FIR
//                tap reader (sample buffer pointer and pair index widths,
//                reader state encoding).
//  Revision    : 1.0  initial release
// ============================================================================
package sfir_pkg;

  // Pointer into the circular sample buffer of depth 2*nbtap.
  function automatic int ptr_width(input int nbtap);
    return $clog2(2 * nbtap);
  endfunction

  // Index of a symmetric pair, 0..nbtap-1 (nbtap >= 2 keeps this >= 1 bit).
  function automatic int idx_width(input int nbtap);
    return $clog2(nbtap);
  endfunction

  // Reader states: waiting for a sample, or presenting the pair burst.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } sfir_state_e;

endpackage : sfir_pkg
`default_nettype wire

// File: rtl/sfir_sample_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sfir_sample_ram
//  Description : 2*NBTAP x DSIZE circular sample store. One synchronous
//                write port, two asynchronous read ports (distributed RAM).
//                Contents are never reset; stale entries are masked by the
//                reader's fill count.
//  Revision    : 1.0  initial release
// ============================================================================
module sfir_sample_ram
  import sfir_pkg::*;
#(
  parameter int DSIZE = 16,
  parameter int NBTAP = 4
) (
  input  logic                          clk,
  input  logic                          we_i,
  input  logic [ptr_width(NBTAP)-1:0]   waddr_i,
  input  logic [DSIZE-1:0]              wdata_i,
  input  logic [ptr_width(NBTAP)-1:0]   raddr_a_i,
  output logic [DSIZE-1:0]              rdata_a_o,
  input  logic [ptr_width(NBTAP)-1:0]   raddr_b_i,
  output logic [DSIZE-1:0]              rdata_b_o
);

  localparam int DEPTH = 2 * NBTAP;

  logic [DSIZE-1:0] mem_q [DEPTH];

  // Write the accepted sample into its slot.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Both taps of a pair are read combinationally in the same cycle.
  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule : sfir_sample_ram
`default_nettype wire

// File: rtl/sfir_tap_reader.sv
`default_nettype none
// ============================================================================
//  Module      : sfir_tap_reader
//  Description : Consumer-side reader of the symmetric FIR delay line.
//                Each accepted sample is stored in a circular buffer of
//                depth 2*NBTAP, then NBTAP symmetric pairs (age k and age
//                2*NBTAP-1-k) are presented with their full-precision sum,
//                one pair per handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module sfir_tap_reader
  import sfir_pkg::*;
#(
  parameter int DSIZE = 16,
  parameter int NBTAP = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        din_valid_i,
  output logic                        din_ready_o,
  input  logic [DSIZE-1:0]            datain_i,
  output logic                        pair_valid_o,
  input  logic                        pair_ready_i,
  output logic [DSIZE-1:0]            pair_a_o,
  output logic [DSIZE-1:0]            pair_b_o,
  output logic [DSIZE:0]              pair_sum_o,
  output logic [idx_width(NBTAP)-1:0] pair_idx_o,
  output logic                        pair_first_o,
  output logic                        pair_last_o
);

  localparam int DEPTH  = 2 * NBTAP;
  localparam int PTR_W  = ptr_width(NBTAP);
  localparam int IDX_W  = idx_width(NBTAP);
  localparam int FILL_W = $clog2(DEPTH + 1);

  localparam logic [IDX_W-1:0]  K_LAST   = IDX_W'(NBTAP - 1);
  localparam logic [PTR_W-1:0]  WP_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  AGE_MAX  = PTR_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  // Buffer slot holding the sample of the given age, modulo DEPTH.
  // DEPTH need not be a power of two, so the wrap is done by compare.
  function automatic logic [PTR_W-1:0] age_addr(input logic [PTR_W-1:0] wp,
                                                 input logic [PTR_W-1:0] age);
    if (wp >= age) begin
      return wp - age;
    end
    return PTR_W'({1'b0, wp} + (PTR_W+1)'(DEPTH) - {1'b0, age});
  endfunction

  sfir_state_e        state_q, state_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic [PTR_W-1:0]   wp_q, wp_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               load_d;

  logic [DSIZE-1:0]   pair_a_q, pair_a_d;
  logic [DSIZE-1:0]   pair_b_q, pair_b_d;
  logic [DSIZE:0]     pair_sum_q, pair_sum_d;
  logic               pair_first_q, pair_first_d;
  logic               pair_last_q, pair_last_d;

  logic [PTR_W-1:0]   age_a, age_b;
  logic [PTR_W-1:0]   addr_a, addr_b;
  logic [DSIZE-1:0]   rd_a, rd_b;
  logic               ram_we;

  // The newest sample lands at wp on the accepting edge; wp only moves
  // once the whole burst has been consumed, so it stays age 0 meanwhile.
  assign ram_we = (state_q == IDLE) && din_valid_i && !rst;

  sfir_sample_ram #(
    .DSIZE (DSIZE),
    .NBTAP (NBTAP)
  ) u_ram (
    .clk       (clk),
    .we_i      (ram_we),
    .waddr_i   (wp_q),
    .wdata_i   (datain_i),
    .raddr_a_i (addr_a),
    .rdata_a_o (rd_a),
    .raddr_b_i (addr_b),
    .rdata_b_o (rd_b)
  );

  // State, pair index, write pointer and fill count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      wp_q    <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wp_q    <= wp_d;
      fill_q  <= fill_d;
    end
  end

  // Next-state logic: accept one sample, then walk k through the pairs.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wp_d    = wp_q;
    fill_d  = fill_q;
    load_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (din_valid_i) begin
          state_d = EMIT;
          k_d     = '0;
          load_d  = 1'b1;
        end
      end
      EMIT: begin
        if (pair_ready_i) begin
          if (k_q == K_LAST) begin
            state_d = IDLE;
            wp_d    = (wp_q == WP_LAST) ? '0 : wp_q + PTR_W'(1);
            fill_d  = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
          end else begin
            k_d    = k_q + IDX_W'(1);
            load_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Fetch and pre-add the taps of the pair that will be shown next.
  // fill_q excludes the sample of the current burst, so age j is live
  // when j <= fill_q.
  always_comb begin
    age_a    = PTR_W'(k_d);
    age_b    = AGE_MAX - PTR_W'(k_d);
    addr_a   = age_addr(wp_q, age_a);
    addr_b   = age_addr(wp_q, age_b);
    pair_a_d = '0;
    pair_b_d = '0;
    if (state_q == IDLE) begin
      // Age 0 on the accepting edge is not in the RAM yet: bypass it.
      pair_a_d = datain_i;
    end else if (int'(age_a) <= int'(fill_q)) begin
      pair_a_d = rd_a;
    end
    if (int'(age_b) <= int'(fill_q)) begin
      pair_b_d = rd_b;
    end
    pair_sum_d   = {pair_a_d[DSIZE-1], pair_a_d} + {pair_b_d[DSIZE-1], pair_b_d};
    pair_first_d = (k_d == '0);
    pair_last_d  = (k_d == K_LAST);
  end

  // Registered pair outputs; held stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_a_q     <= '0;
      pair_b_q     <= '0;
      pair_sum_q   <= '0;
      pair_first_q <= 1'b0;
      pair_last_q  <= 1'b0;
    end else if (load_d) begin
      pair_a_q     <= pair_a_d;
      pair_b_q     <= pair_b_d;
      pair_sum_q   <= pair_sum_d;
      pair_first_q <= pair_first_d;
      pair_last_q  <= pair_last_d;
    end
  end

  assign din_ready_o  = (state_q == IDLE) && !rst;
  assign pair_valid_o = (state_q == EMIT);
  assign pair_a_o     = pair_a_q;
  assign pair_b_o     = pair_b_q;
  assign pair_sum_o   = pair_sum_q;
  assign pair_idx_o   = k_q;
  assign pair_first_o = pair_first_q;
  assign pair_last_o  = pair_last_q;

endmodule : sfir_tap_reader
`default_nettype wire
